// File: rtl/div_sched_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// start_i is held high by EX while stallreq_for_ex is high. ready_o is a one-cycle result strobe. annul_i cancels work in flight.
interface div_sched_if;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_for_ex;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_for_ex
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_for_ex
  );
endinterface

// File: rtl/div_sched.sv
// 32-cycle restoring divider for DIV/DIVU with pipeline stall and flush handling.
// Define DIV_SIGNED_EN to honour signed_i; without it every operation is unsigned.
module div_sched (
  input  logic             clk,
  input  logic             resetn,
  div_sched_if.slave       bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] rem;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [63:0] final_res;

  // One restoring step: the dividend shifts out of quo into rem while quotient bits shift in.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end
  end

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    abs1      = (bus.signed_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    abs2      = (bus.signed_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
    final_res = {(neg_r ? (32'd0 - rem_next) : rem_next),
                 (neg_q ? (32'd0 - quo_next) : quo_next)};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == FREE && bus.start_i && !bus.annul_i) begin
      neg_q <= bus.signed_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
      neg_r <= bus.signed_i && bus.opdata1_i[31];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.signed_i;

  always_comb begin
    abs1      = bus.opdata1_i;
    abs2      = bus.opdata2_i;
    final_res = {rem_next, quo_next};
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= FREE;
      cnt          <= 5'd0;
      quo          <= 32'd0;
      dvs          <= 32'd0;
      rem          <= 32'd0;
      bus.ready_o  <= 1'b0;
      bus.result_o <= 64'd0;
    end else begin
      case (state)
        FREE: begin
          bus.ready_o  <= 1'b0;
          bus.result_o <= 64'd0;
          if (bus.start_i && !bus.annul_i) begin
            quo   <= abs1;
            dvs   <= abs2;
            rem   <= 32'd0;
            cnt   <= 5'd0;
            state <= (bus.opdata2_i == 32'd0) ? BY_ZERO : ON;
          end
        end
        BY_ZERO: begin
          if (bus.annul_i) begin
            state <= FREE;
          end else begin
            state        <= END;
            bus.ready_o  <= 1'b1;
            bus.result_o <= 64'd0;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            state <= FREE;
          end else begin
            quo <= quo_next;
            rem <= rem_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state        <= END;
              bus.ready_o  <= 1'b1;
              bus.result_o <= final_res;
            end
          end
        end
        END: begin
          // The result is already committed, so a flush here does not cancel it.
          state        <= FREE;
          bus.ready_o  <= 1'b0;
          bus.result_o <= 64'd0;
        end
        default: state <= FREE;
      endcase
    end
  end

  assign bus.stallreq_for_ex = bus.start_i && (state != END);
  assign dbg_state           = state;

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 The block SHALL have a clk port, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a resetn port, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have a start_i port, input, 1 bit: EX holds a DIV/DIVU and requests the divider.
REQ-004 The block SHALL have a signed_i port, input, 1 bit: 1 = DIV (signed), 0 = DIVU.
REQ-005 The block SHALL have an opdata1_i port, input, 32 bits: dividend.
REQ-006 The block SHALL have an opdata2_i port, input, 32 bits: divisor.
REQ-007 The block SHALL have an annul_i port, input, 1 bit: flush; cancels any operation in flight.
REQ-008 The block SHALL have a result_o port, output, 64 bits: {remainder[63:32], quotient[31:0]}, for HI/LO.
REQ-009 The block SHALL have a ready_o port, output, 1 bit: result_o valid this cycle.
REQ-010 The block SHALL have a stallreq_for_ex port, output, 1 bit: stall request to the pipeline controller, combinational.

Function
REQ-011 The block SHALL implement a four-state FSM: FREE, BY_ZERO, ON, END.
REQ-012 In FREE with start_i=1 and annul_i=0, the block SHALL latch the operands and signedness, and go to BY_ZERO if opdata2_i==0, else to ON with the iteration counter cleared.
REQ-013 In FREE with start_i=0, or with annul_i=1, the block SHALL stay in FREE.
REQ-014 In ON, the block SHALL run one restoring shift/subtract step per cycle on the latched absolute values, for exactly 32 cycles.
REQ-015 After the 32nd ON step, the block SHALL go to END.
REQ-016 In BY_ZERO, the block SHALL go to END next cycle with result 0.
REQ-017 Latency: start sampled in FREE at cycle T gives ready_o=1 at T+33 (nonzero divisor) or at T+2 (zero divisor).
REQ-018 In END, the block SHALL drive ready_o=1 and result_o valid for exactly one cycle, then go unconditionally to FREE.
REQ-019 In every other state, the block SHALL drive ready_o=0 and result_o=0.
REQ-020 stallreq_for_ex SHALL equal start_i AND (state != END), so EX stays stalled from the request cycle until the result cycle.
REQ-021 annul_i=1 in ON or BY_ZERO SHALL force FREE next cycle, with no ready_o and no result.
REQ-022 annul_i=1 in END SHALL still complete END, because the result is already committed.
REQ-023 For signed division, the operands SHALL be converted to absolute values at latch time.
REQ-024 For signed division, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (two's-complement wrap).
REQ-026 Changes on opdata1_i, opdata2_i or signed_i after the start cycle SHALL NOT affect the operation in flight.

Reset
REQ-027 resetn=0 at a rising edge SHALL force FREE, clear the counter, the operand registers and the partial remainder, and drive ready_o=0 and result_o=0.
REQ-028 stallreq_for_ex SHALL follow REQ-020 with state=FREE.
REQ-029 Reset asserted mid-operation SHALL abort that operation with no ready_o pulse, regardless of annul_i.

Configuration
REQ-030 The block SHALL support the macro DIV_SIGNED_EN.
REQ-031 With DIV_SIGNED_EN defined, signed_i SHALL be honoured per REQ-023..REQ-025.
REQ-032 Without DIV_SIGNED_EN, signed_i SHALL be ignored, all operations SHALL be unsigned, and no sign-fixup logic SHALL be synthesized.
REQ-033 Latency and the handshake SHALL be identical in both builds.

Verification
REQ-034 The bench SHALL apply DIVU 100/7 starting at cycle T and check: ready_o=1 only at T+33, result_o={32'd2, 32'd14}, and stallreq_for_ex=1 from T to T+32 and 0 at T+33.
REQ-035 The bench SHALL apply DIV -7/2 with DIV_SIGNED_EN defined and check result_o={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-036 The bench SHALL run the same DIV -7/2 build without DIV_SIGNED_EN and check unsigned result_o={32'h1, 32'h7FFFFFFC}.
REQ-037 The bench SHALL apply divisor 0 at T and check ready_o=1 at T+2 with result_o=0, and stallreq_for_ex low at T+2.
REQ-038 The bench SHALL pulse annul_i at T+10 of a normal divide and check: FREE at T+11, no ready_o through T+40, and a new start at T+12 completing at T+45.
REQ-039 The bench SHALL drop resetn at T+20 of a divide and check: no ready_o, state FREE, and stallreq_for_ex=start_i afterwards.
REQ-040 The bench SHALL apply DIVU 0xFFFFFFFF/1 and check result_o={32'h0, 32'hFFFFFFFF}.
